arb_2_1: RTL
============

ARB_2_1 -- requirements
Module: arb_2_1

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the data width of each input and of the output.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-004 The port a_valid SHALL be an input, 1 bit wide, meaning source A offers a_data.
REQ-005 The port a_data SHALL be an input, WIDTH bits wide, carrying the source A payload.
REQ-006 The port a_ready SHALL be an output, 1 bit wide, meaning A's word is accepted this cycle.
REQ-007 The port b_valid SHALL be an input, 1 bit wide, meaning source B offers b_data.
REQ-008 The port b_data SHALL be an input, WIDTH bits wide, carrying the source B payload.
REQ-009 The port b_ready SHALL be an output, 1 bit wide, meaning B's word is accepted this cycle.
REQ-010 The port out_valid SHALL be an output, 1 bit wide, meaning out_data holds a granted word.
REQ-011 The port out_data SHALL be an output, WIDTH bits wide, carrying the registered winning payload.
REQ-012 The port out_ready SHALL be an input, 1 bit wide, meaning the downstream consumer takes out_data this cycle.
REQ-013 The port sel SHALL be an output, 1 bit wide, giving the source of the word in out_data: 1 for A, 0 for B; it drives the downstream 2:1 mux select.

Function
REQ-014 The block SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The load condition SHALL be load = !out_valid | out_ready.
REQ-016 A grant SHALL occur only when load=1 and at least one of a_valid or b_valid is 1; a_ready and b_ready SHALL be combinational, and at most one SHALL be 1 in any cycle.
REQ-017 On a grant, out_data and sel SHALL register the winner's data and source, and out_valid SHALL be 1 in the next cycle; latency from input to output is one cycle.
REQ-018 Under a single request, that requester SHALL win.
REQ-019 When both sources request at once, the winner SHALL be the source not granted last (round-robin), tracked in register last_a.
REQ-020 The FSM SHALL move EMPTY->FULL on a grant.
REQ-021 The FSM SHALL move FULL->EMPTY when out_ready=1 and no grant occurs.
REQ-022 The FSM SHALL stay FULL when out_ready=1 and a grant occurs in the same cycle, giving back-to-back throughput of one word per cycle.
REQ-023 While FULL with out_ready=0, out_data, sel and out_valid SHALL hold stable, and a_ready and b_ready SHALL be 0.
REQ-024 last_a SHALL update only on a grant.
REQ-025 out_data and sel SHALL NOT change in any cycle without a grant.

Reset
REQ-026 While rst=1: out_valid=0, out_data=0, sel=0, last_a=0 (A wins the first tie), and a_ready=b_ready=0 regardless of inputs.
REQ-027 A reset asserted while FULL SHALL discard the held word with no output transfer; the first cycle after rst falls behaves as EMPTY.

Configuration
REQ-028 The macro ARB_2_1_FIXED_PRI_EN SHALL control tie-breaking: when it is defined, A always wins ties and last_a is not implemented; when it is undefined, the round-robin of REQ-019 applies.

Verification
REQ-029 Scenario 1: reset, then a_valid=1, a_data=8'h5A, out_ready=1 -> a_ready=1 the same cycle; next cycle out_valid=1, out_data=8'h5A, sel=1.
REQ-030 Scenario 2: a_valid=b_valid=1 held for 4 cycles with out_ready=1 (a_data=8'h11, b_data=8'h22) -> sel sequence 1,0,1,0 and out_data sequence 11,22,11,22; with the macro defined -> sel 1,1,1,1.
REQ-031 Scenario 3: FULL with out_ready=0 for 3 cycles while b_valid=1 -> b_ready=0 and out_data stable; out_ready=1 -> b_ready=1 that cycle, then the B word appears next cycle.
REQ-032 Scenario 4: after one A word, drop both valids, out_ready=1 -> out_valid=1 for exactly one cycle, then 0.
REQ-033 Scenario 5: rst=1 mid-stream while FULL with out_ready=0 -> next cycle out_valid=0, sel=0, out_data=0; the first tie after reset goes to A.
REQ-034 All scenarios SHALL check per cycle that a_ready&b_ready is never 1 and that the word count in equals the word count out.

Source files
------------

// File: rtl/arb_2_1_if.sv
// arb_2_1_if -- handshake bundle for the 2:1 arbiter.
// Groups both source channels (valid/data/ready), the output channel
// and the downstream mux select. The "slave" modport is the arbiter's
// view; the "master" modport is the view of whatever drives the sources
// and consumes the output.
interface arb_2_1_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, sel
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/arb_2_1.sv
// arb_2_1 -- two-source arbiter with a one-word registered output stage.
// A word is taken from A or B whenever the output register is empty or
// being drained this cycle, giving one word per cycle when both sides
// stream. Ties are broken round-robin by default; defining the macro
// ARB_2_1_FIXED_PRI_EN makes A always win ties and removes last_a.
// Reset is synchronous and active-high.
module arb_2_1 #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    arb_2_1_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             held_valid;
    logic [WIDTH-1:0] held_data;
    logic             held_sel;

    logic             load;
    logic             pick_a;
    logic             grant;

`ifndef ARB_2_1_FIXED_PRI_EN
    logic             last_a;
`endif

    // Grant decision: output slot free or draining, at least one requester
    always_comb begin
        load = !held_valid | bus.out_ready;
`ifdef ARB_2_1_FIXED_PRI_EN
        pick_a = bus.a_valid;
`else
        pick_a = bus.a_valid & (!bus.b_valid | !last_a);
`endif
        grant = !rst & load & (bus.a_valid | bus.b_valid);
    end

    assign bus.a_ready   = grant & pick_a;
    assign bus.b_ready   = grant & !pick_a;
    assign bus.out_valid = held_valid;
    assign bus.out_data  = held_data;
    assign bus.sel       = held_sel;

    // Output-stage FSM: capture the winner on a grant, empty when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            held_valid <= 1'b0;
            held_data  <= '0;
            held_sel   <= 1'b0;
`ifndef ARB_2_1_FIXED_PRI_EN
            last_a     <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (grant) begin
                        state      <= FULL;
                        held_valid <= 1'b1;
                        held_data  <= pick_a ? bus.a_data : bus.b_data;
                        held_sel   <= pick_a;
`ifndef ARB_2_1_FIXED_PRI_EN
                        last_a     <= pick_a;
`endif
                    end
                end
                FULL: begin
                    if (grant) begin
                        held_data  <= pick_a ? bus.a_data : bus.b_data;
                        held_sel   <= pick_a;
`ifndef ARB_2_1_FIXED_PRI_EN
                        last_a     <= pick_a;
`endif
                    end else if (bus.out_ready) begin
                        state      <= EMPTY;
                        held_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    held_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
